// File: rtl/mdu_iter_if.sv
// Request/result bundle between the multicycle control path and the iterative MDU.
interface mdu_iter_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic            div_zero;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// Define MDU_FAST_MULT_EN to compute multiplies in a single cycle instead of iteratively.
module mdu_iter #(
  parameter int unsigned XLEN = 32
) (
  input logic       clk,
  input logic       rst_n,
  mdu_iter_if.slave bus_io
);
  localparam int unsigned CntW = $clog2(XLEN) + 1;
  localparam int unsigned AccW = 2 * XLEN;

  typedef enum logic [1:0] {StIdle, StCalc, StFixup} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [AccW-1:0] acc_q, acc_d;   // {P_hi, P_lo} for multiply, {R, Q} for divide
  logic [XLEN-1:0] opd_q, opd_d;   // multiplicand or divisor magnitude
  logic            is_div_q, is_div_d;
  logic            neg_res_q, neg_res_d;
  logic            neg_rem_q, neg_rem_d;
  logic            dz_q, dz_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic            done_q, done_d;
  logic            dz_pulse_q, dz_pulse_d;

  logic            op_mul, op_div, op_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  assign op_mul    = (bus_io.op[2:1] == 2'b00);
  assign op_div    = (bus_io.op[2:1] == 2'b01);
  assign op_signed = ~bus_io.op[0];
  assign a_neg     = op_signed & bus_io.a[XLEN-1];
  assign b_neg     = op_signed & bus_io.b[XLEN-1];
  assign a_mag     = a_neg ? -bus_io.a : bus_io.a;
  assign b_mag     = b_neg ? -bus_io.b : bus_io.b;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_rem;
  logic [XLEN:0]   div_diff;
  logic [AccW-1:0] prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix;

  assign mul_sum  = {1'b0, acc_q[AccW-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
  // Remainder after the left shift keeps one extra bit so 2*R+1 never overflows.
  assign div_rem  = acc_q[AccW-1:XLEN-1];
  assign div_diff = div_rem - {1'b0, opd_q};

  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quo_fix  = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix  = neg_rem_q ? -acc_q[AccW-1:XLEN] : acc_q[AccW-1:XLEN];

`ifdef MDU_FAST_MULT_EN
  logic [AccW-1:0] fast_a, fast_b, fast_prod;
  assign fast_a    = {{XLEN{a_neg}}, bus_io.a};
  assign fast_b    = {{XLEN{b_neg}}, bus_io.b};
  assign fast_prod = fast_a * fast_b;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opd_d      = opd_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    dz_pulse_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          if (op_mul || op_div) begin
            is_div_d  = op_div;
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            dz_d      = op_div && (bus_io.b == '0);
            cnt_d     = '0;
            state_d   = StCalc;
            if (op_div) begin
              acc_d = {{XLEN{1'b0}}, a_mag};
              opd_d = b_mag;
            end else begin
              acc_d = {{XLEN{1'b0}}, b_mag};
              opd_d = a_mag;
            end
`ifdef MDU_FAST_MULT_EN
            if (op_mul) begin
              acc_d     = fast_prod;
              neg_res_d = 1'b0;
              state_d   = StFixup;
            end
`endif
          end else if (bus_io.op == 3'b100) begin
            hi_d = bus_io.a;
          end else if (bus_io.op == 3'b101) begin
            lo_d = bus_io.a;
          end
        end
      end
      StCalc: begin
        if (is_div_q) begin
          acc_d = div_diff[XLEN] ? {acc_q[AccW-2:0], 1'b0}
                                 : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(XLEN - 1)) begin
          state_d = StFixup;
        end
      end
      StFixup: begin
        state_d    = StIdle;
        done_d     = 1'b1;
        dz_pulse_d = dz_q;
        if (!is_div_q) begin
          hi_d = prod_fix[AccW-1:XLEN];
          lo_d = prod_fix[XLEN-1:0];
        end else if (!dz_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      opd_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dz_pulse_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opd_q      <= opd_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      dz_pulse_q <= dz_pulse_d;
    end
  end

  assign bus_io.busy     = (state_q != StIdle);
  assign bus_io.done     = done_q;
  assign bus_io.div_zero = dz_pulse_q;
  assign bus_io.hi       = hi_q;
  assign bus_io.lo       = lo_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: fixed vectors, hand-written corner sequences and random ops vs a model.
module tb_mdu_iter;
  localparam int unsigned XLEN = 32;
  localparam int DivLat = XLEN + 1;
`ifdef MDU_FAST_MULT_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = XLEN + 1;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic saw_busy;
  logic [31:0] exp_hi, exp_lo;

  mdu_iter_if #(.XLEN(XLEN)) bus ();

  mdu_iter #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; returns {div_zero, hi, lo}.
  function automatic logic [64:0] model(input logic [2:0] o, input logic [31:0] av,
                                        input logic [31:0] bv, input logic [31:0] ph,
                                        input logic [31:0] pl);
    logic [63:0] p;
    longint sa, sb, q, r;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    case (o)
      3'd0: begin
        p = sa * sb;
        return {1'b0, p};
      end
      3'd1: begin
        p = {32'b0, av} * {32'b0, bv};
        return {1'b0, p};
      end
      3'd2: begin
        if (bv == 32'd0) return {1'b1, ph, pl};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      3'd3: begin
        if (bv == 32'd0) return {1'b1, ph, pl};
        return {1'b0, av % bv, av / bv};
      end
      3'd4: return {1'b0, av, pl};
      3'd5: return {1'b0, ph, av};
      default: return {1'b0, ph, pl};
    endcase
  endfunction

  // Called #1 after a clock edge; the start edge is the next posedge.
  task automatic run_md(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input string tag, input logic [31:0] eh, input logic [31:0] el,
                        input logic edz);
    int n, nb, lat;
    logic hold_ok;
    logic [31:0] h0, l0;
    lat = (o[2:1] == 2'b00) ? MulLat : DivLat;
    h0 = bus.hi;
    l0 = bus.lo;
    hold_ok = 1'b1;
    bus.start = 1'b1;
    bus.op = o;
    bus.a = av;
    bus.b = bv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op = 3'($urandom_range(0, 7));
    bus.a = $urandom;
    bus.b = $urandom;
    n = 0;
    nb = 0;
    while (!bus.done && n < 200) begin
      if (bus.busy) nb++;
      if (bus.hi !== h0 || bus.lo !== l0) hold_ok = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(lat));
    check({tag, " busy cycles"}, 64'(nb), 64'(lat));
    check({tag, " busy at done"}, 64'(bus.busy), 64'd0);
    check({tag, " hi/lo held"}, 64'(hold_ok), 64'd1);
    check({tag, " hi"}, 64'(bus.hi), 64'(eh));
    check({tag, " lo"}, 64'(bus.lo), 64'(el));
    check({tag, " div_zero"}, 64'(bus.div_zero), 64'(edz));
  endtask

  task automatic run_mt(input logic [2:0] o, input logic [31:0] av);
    bus.start = 1'b1;
    bus.op = o;
    bus.a = av;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (bus.busy) saw_busy = 1'b1;
  endtask

  logic [2:0]  r_op;
  logic [31:0] r_a, r_b;
  logic [64:0] m;
  logic        seen;

  initial begin
    checks = 0;
    errors = 0;
    saw_busy = 1'b0;
    bus.start = 1'b0;
    bus.op = 3'd0;
    bus.a = '0;
    bus.b = '0;
    rst_n = 1'b0;

    vecs[0] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{3'd0, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{3'd3, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
    vecs[4] = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[5] = '{3'd3, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
    vecs[6] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[7] = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[8] = '{3'd2, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002};

    repeat (2) @(posedge clk);
    #1;
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset div_zero", 64'(bus.div_zero), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_mt(3'd4, 32'h1234_5678);
    run_mt(3'd5, 32'hCAFE_BABE);
    check("mthi hi", 64'(bus.hi), 64'h1234_5678);
    check("mtlo lo", 64'(bus.lo), 64'hCAFE_BABE);
    check("mthi/mtlo busy", 64'(saw_busy), 64'd0);

    for (int i = 0; i < 9; i++) begin
      run_md(vecs[i].op, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i),
             vecs[i].hi, vecs[i].lo, 1'b0);
    end

    run_mt(3'd4, 32'hAAAA_0000);
    run_mt(3'd5, 32'h0000_BBBB);
    run_md(3'd3, 32'd100, 32'd0, "divu by zero", 32'hAAAA_0000, 32'h0000_BBBB, 1'b1);
    check("divu by zero done", 64'(bus.done), 64'd1);
    @(posedge clk);
    #1;
    check("div_zero one cycle", 64'(bus.div_zero), 64'd0);
    check("done one cycle", 64'(bus.done), 64'd0);

    run_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div overflow", 32'h0, 32'h8000_0000, 1'b0);
    run_md(3'd1, 32'd3, 32'd5, "back-to-back multu", 32'h0, 32'd15, 1'b0);
    exp_hi = 32'h0;
    exp_lo = 32'd15;

    // Ignored MTLO mid-divide, then asynchronous reset aborts the divide.
    bus.start = 1'b1;
    bus.op = 3'd2;
    bus.a = 32'hFFFF_FFF9;
    bus.b = 32'd2;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op = 3'd5;
    bus.a = 32'h55;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("mtlo while busy ignored", 64'(bus.lo), 64'(exp_lo));
    check("busy mid divide", 64'(bus.busy), 64'd1);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async reset hi", 64'(bus.hi), 64'd0);
    check("async reset lo", 64'(bus.lo), 64'd0);
    check("async reset busy", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen = 1'b1;
    end
    check("aborted op silent", 64'(seen), 64'd0);
    exp_hi = 32'h0;
    exp_lo = 32'h0;

    for (int i = 0; i < 40; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a = $urandom;
      r_b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) r_b = r_b & 32'hF;
      m = model(r_op, r_a, r_b, exp_hi, exp_lo);
      if (r_op <= 3'd3) begin
        run_md(r_op, r_a, r_b, $sformatf("rand%0d op%0d", i, r_op), m[63:32], m[31:0], m[64]);
      end else begin
        saw_busy = 1'b0;
        run_mt(r_op, r_a);
        check($sformatf("rand%0d op%0d busy", i, r_op), 64'(saw_busy), 64'd0);
        check($sformatf("rand%0d op%0d hi", i, r_op), 64'(bus.hi), 64'(m[63:32]));
        check($sformatf("rand%0d op%0d lo", i, r_op), 64'(bus.lo), 64'(m[31:0]));
      end
      exp_hi = m[63:32];
      exp_lo = m[31:0];
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit beside the multicycle datapath's ALU; takes the same A/B operand-register outputs the ALU consumes.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and MTHI/MTLO in one; holds the architectural HI/LO registers.
- The control FSM stalls on busy; HI/LO feed the writeback mux for MFHI/MFLO.

Parameters:
- XLEN, 32, operand/HI/LO width; counter sized to clog2(XLEN)+1.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request strobe, sampled on clk rising edge
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved (ignored)
- A  in  XLEN  rs operand (multiplicand/dividend; MTHI/MTLO source)
- B  in  XLEN  rt operand (multiplier/divisor)
- busy  out  1  operation in progress, start ignored
- done  out  1  one-cycle pulse: HI/LO updated by a mult/div
- div_zero  out  1  one-cycle pulse with done: divisor was zero
- hi  out  XLEN  architectural HI
- lo  out  XLEN  architectural LO

Behaviour:
- Reset (async, rst_n low): state=IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, counter and working regs cleared. Deasserting reset mid-operation leaves the unit idle; the aborted op is lost.
- States: IDLE, CALC, FIXUP.
- IDLE, start=1, op=MTHI/MTLO:
  - hi (or lo) <= A at that edge; no busy, no done.
- IDLE, start=1, op=mult/div:
  - Latch operand magnitudes and result signs; signed ops take the two's-complement abs of negative inputs.
  - Counter <= 0; state -> CALC; busy=1 from the next cycle.
- IDLE, start=1, op reserved: no effect.
- CALC, multiply:
  - Radix-2 shift-add, one multiplier bit per cycle.
  - 2*XLEN-bit accumulator {P_hi,P_lo}; if P_lo[0] is set, add the multiplicand into P_hi with carry; shift right by 1.
- CALC, divide:
  - Restoring division, one quotient bit per cycle.
  - Shift {R,Q} left by 1; trial-subtract divisor from R.
  - If no borrow: keep the difference and set Q[0]=1; else restore R.
- CALC runs exactly XLEN cycles (counter 0..XLEN-1), then state -> FIXUP.
- FIXUP (1 cycle):
  - Apply signs. MULT: negate the 64-bit product if operand signs differ. DIV: negate the quotient if signs differ; the remainder takes the dividend's sign.
  - Write hi/lo: mult hi=product[63:32], lo=product[31:0]; div lo=quotient, hi=remainder.
  - done=1 and busy=0 on the following cycle; state -> IDLE.
- Latency: start sampled at edge E0 -> done high in the cycle after edge E(XLEN+1) (E33 for XLEN=32).
  - busy high for XLEN+1 cycles; done and busy=0 coincide.
  - A new start is accepted in the done cycle.
- start while busy: ignored entirely, including MTHI/MTLO; hi/lo are not disturbed.
- A/B need only be valid in the start cycle; the unit never re-reads them.
- hi/lo hold their previous values throughout CALC; all computation uses working registers.
- Divide by zero:
  - Detected at start; still takes the full latency.
  - hi/lo are left unchanged (not written in FIXUP).
  - div_zero pulses with done.
- DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0, no exception.
- Signed division truncates toward zero.

Optional Feature:
- Macro: MDU_FAST_MULT_EN.
- Defined: MULT/MULTU bypass CALC. At the start edge the full 2*XLEN product (signed or unsigned `*`) goes into the accumulator and state -> FIXUP. done arrives in the cycle after E1; busy is high for 1 cycle.
- Undefined: the iterative multiplier is used and the multiply latency is identical to divide.
- Division is iterative in both builds.

Test Plan:
- Reset, then MTHI A=0x12345678 and next cycle MTLO A=0xCAFEBABE -> hi=0x12345678, lo=0xCAFEBABE; busy never asserted.
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> done in the cycle after E33 (after E1 with MDU_FAST_MULT_EN); hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 33 cycles (1 with macro).
- MULT A=0xFFFFFFF9 (-7) B=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). Then DIV A=-7 B=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then DIVU A=7 B=2 -> lo=3, hi=1.
- DIVU A=100 B=0 with hi/lo preset to 0xAAAA0000/0x0000BBBB -> done and div_zero pulse together; hi/lo unchanged.
- During a DIV: pulse start with MTLO A=0x55 at cycle 10 -> ignored. Then drop rst_n at cycle 20 -> hi=lo=0, busy=0 immediately. After release, no done ever appears.
- Back-to-back: new MULTU 3*5 issued in the done cycle of DIV 0x80000000/-1 -> first gives lo=0x80000000, hi=0; second gives lo=15, hi=0, done XLEN+1 cycles later.
